keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed 7-segment display path. It scans a 4x4 matrix keypad by driving one row low at a time and sampling the columns. Each press is debounced, encoded to a 4-bit hex code and shifted into a 32-bit KeyData word, in the same eight-hex-digit format the display path consumes. A valid/ack handshake delivers each key event to the CPU/IO bus.

Parameters:
SCAN_DIV, 5000, CLK cycles per scan tick; same cadence as the display digit multiplexer; must be >= 2.
DEBOUNCE_SCANS, 4, consecutive stable scan ticks required to accept a press or a release; must be >= 1.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
ROW  output  4  keypad row drive, one-cold (active-low)
COL  input  4  keypad column sense, active-low (pulled up off-chip); asynchronous
KeyData  output  32  history of accepted keys, newest in [3:0]
KeyCode  output  4  code of most recent accepted key
KeyValid  output  1  new key pending
KeyAck  input  1  consumer acknowledge

Behaviour:
- Reset values (synchronous, active-high): ROW=4'b1110, KeyData=0, KeyCode=0, KeyValid=0, FSM=SCAN, tick and debounce counters=0, COL synchronizer=4'b1111.
- COL passes through a 2-FF synchronizer; all decisions use the synced value.
- Tick generator: 1-cycle pulse every SCAN_DIV CLK cycles. The counter runs 0..SCAN_DIV-1; the pulse fires on wrap.
- FSM state changes and ROW changes occur only on tick cycles. Exceptions: handshake logic, and RST, which acts on every cycle.
- Row index r selects ROW: r=0 gives 1110, r=1 gives 1101, r=2 gives 1011, r=3 gives 0111.
- Columns are read one full tick after ROW changes, allowing settle time.
- SCAN state, on tick:
  - If synced COL==4'b1111, advance r (3 wraps to 0).
  - Otherwise latch the COL pattern, hold r, clear the debounce counter and go to DEBOUNCE.
- DEBOUNCE state, on tick:
  - If COL equals the latched pattern, increment the counter.
  - When the count reaches DEBOUNCE_SCANS, accept the key and go to HOLD.
  - On any mismatch, return to SCAN and advance r.
- Accept action, in the same cycle:
  - c = index of the lowest-numbered low bit of the latched COL (multi-column presses resolve to the lowest index).
  - KeyCode = {r[1:0], c[1:0]}.
  - KeyData = {KeyData[27:0], KeyCode}.
  - KeyValid=1.
- HOLD state (waiting for release), on tick:
  - Count consecutive ticks with COL==4'b1111; any low column clears the count.
  - At DEBOUNCE_SCANS, go to SCAN and advance r.
  - A second key pressed while in HOLD is ignored (no rollover).
- Handshake:
  - KeyValid clears on the cycle after KeyAck=1 is sampled while KeyValid=1.
  - KeyAck while KeyValid=0 has no effect.
  - Accept and KeyAck in the same cycle: accept wins and KeyValid stays 1.
  - Accept while KeyValid is already 1: KeyCode and KeyData update and KeyValid stays 1 (overrun; see optional feature).
- KeyData keeps only the last 8 codes; the oldest nibble is discarded with no wrap-around.
- RST asserted mid-debounce or mid-hold aborts to reset values. No partial key is recorded.

Optional Feature:
KEYPAD_OVERRUN_EN
- Defined: adds output Overrun (1 bit, reset 0).
  - Set when an accept occurs while KeyValid=1 and KeyAck=0 in that cycle.
  - Sticky; cleared only by the same cycle's KeyAck that clears KeyValid, or by RST.
- Undefined: no Overrun port; overrun silently overwrites KeyCode.

Decomposition:
- Shared package/header keypad_defs:
  - FSM state encoding: SCAN=2'd0, DEBOUNCE=2'd1, HOLD=2'd2.
  - ROW_IDLE=4'b1111 and COL_NONE=4'b1111.
  - Row one-cold table.
- One natural sub-module: scan_tick, a parameterized SCAN_DIV pulse generator with synchronous RST.
- Synchronizer, FSM and handshake stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- Reset, no keys: ROW cycles 1110, 1101, 1011, 0111, 1110 at 4-cycle spacing; KeyValid=0; KeyData=0.
- Stable press at row 2/col 1 for 40 cycles: KeyCode=4'h9; KeyData=32'h00000009; KeyValid=1 until KeyAck, then 0 on the next cycle.
- Bounce: col 0 low for one tick at row 1, then high: no accept; FSM returns to SCAN; ROW advances to 1011.
- Eight presses 1..8 then key F (row 3/col 3), each acked: KeyData=32'h2345678F.
- Two keys accepted without KeyAck (row 0/col 0, then row 3/col 2): KeyCode=4'hE, KeyData=32'h0000000E, KeyValid=1; Overrun=1 when KEYPAD_OVERRUN_EN is defined.
- RST pulsed while in HOLD with a key held: all outputs return to reset values; the held key is re-accepted only after the full debounce completes.

Source files
------------

// File: rtl/keypad_defs.sv
// Shared definitions for the keypad scanner: FSM state encoding, idle row/column
// patterns, the one-cold row drive table and the column-to-index encoder.
package keypad_defs;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_NONE = 4'b1111;

    // Entry r pulls exactly row r low; entry 0 is the rightmost element.
    localparam logic [3:0][3:0] ROW_TABLE = {
        ROW_IDLE ^ 4'b1000,
        ROW_IDLE ^ 4'b0100,
        ROW_IDLE ^ 4'b0010,
        ROW_IDLE ^ 4'b0001
    };

    // Several columns low at once resolve to the lowest-numbered one.
    function automatic logic [1:0] lowestLowCol(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running pulse generator: one-cycle Tick every SCAN_DIV clocks (SCAN_DIV >= 2).
module scan_tick #(
    parameter int SCAN_DIV = 5000
) (
    input  logic CLK,
    input  logic RST,
    output logic Tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(SCAN_DIV - 1));
    assign Tick = wrap;

    always_ff @(posedge CLK) begin
        if (RST)       cnt_q <= '0;
        else if (wrap) cnt_q <= '0;
        else           cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, hex key history and valid/ack handshake.
// Define KEYPAD_OVERRUN_EN to add the sticky Overrun output.
module keypad_scanner
    import keypad_defs::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [3:0]  ROW,
    input  logic [3:0]  COL,
    output logic [31:0] KeyData,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    input  logic        KeyAck
`ifdef KEYPAD_OVERRUN_EN
    ,
    output logic        Overrun
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic             tick;
    logic [3:0]       colMeta_q, colSync_q, colLatch_q;
    state_e           state_q;
    logic [1:0]       rowIdx_q, rowIdx_d;
    logic [3:0]       row_q;
    logic [CNT_W-1:0] debCnt_q, debCnt_d;
    logic [3:0]       keyCode_q, keyCode_d;
    logic [31:0]      keyData_q;
    logic             keyValid_q;
    logic             colMatch_d;
    logic             accept_d;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan_tick (
        .CLK  (CLK),
        .RST  (RST),
        .Tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            colMeta_q <= COL_NONE;
            colSync_q <= COL_NONE;
        end else begin
            colMeta_q <= COL;
            colSync_q <= colMeta_q;
        end
    end

    always_comb begin
        colMatch_d = (colSync_q == colLatch_q);
        debCnt_d   = debCnt_q + CNT_W'(1);
        rowIdx_d   = rowIdx_q + 2'd1;
        accept_d   = tick && (state_q == DEBOUNCE) && colMatch_d
                     && (debCnt_d == CNT_W'(DEBOUNCE_SCANS));
        keyCode_d  = {rowIdx_q, lowestLowCol(colLatch_q)};
    end

    // Scan/debounce/hold sequencing; only tick cycles move state or the row drive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= SCAN;
            rowIdx_q   <= 2'd0;
            row_q      <= ROW_TABLE[0];
            colLatch_q <= COL_NONE;
            debCnt_q   <= '0;
            keyCode_q  <= 4'd0;
            keyData_q  <= 32'd0;
        end else if (tick) begin
            case (state_q)
                SCAN: begin
                    if (colSync_q == COL_NONE) begin
                        rowIdx_q <= rowIdx_d;
                        row_q    <= ROW_TABLE[rowIdx_d];
                    end else begin
                        colLatch_q <= colSync_q;
                        debCnt_q   <= '0;
                        state_q    <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!colMatch_d) begin
                        state_q  <= SCAN;
                        rowIdx_q <= rowIdx_d;
                        row_q    <= ROW_TABLE[rowIdx_d];
                    end else if (accept_d) begin
                        state_q   <= HOLD;
                        debCnt_q  <= '0;
                        keyCode_q <= keyCode_d;
                        keyData_q <= {keyData_q[27:0], keyCode_d};
                    end else begin
                        debCnt_q <= debCnt_d;
                    end
                end
                HOLD: begin
                    // Any low column, including a second key, restarts the release count.
                    if (colSync_q != COL_NONE) begin
                        debCnt_q <= '0;
                    end else if (debCnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                        state_q  <= SCAN;
                        debCnt_q <= '0;
                        rowIdx_q <= rowIdx_d;
                        row_q    <= ROW_TABLE[rowIdx_d];
                    end else begin
                        debCnt_q <= debCnt_d;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    // A fresh accept always wins over an acknowledge landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST)                        keyValid_q <= 1'b0;
        else if (accept_d)              keyValid_q <= 1'b1;
        else if (KeyAck && keyValid_q)  keyValid_q <= 1'b0;
    end

`ifdef KEYPAD_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge CLK) begin
        if (RST)                                       overrun_q <= 1'b0;
        else if (accept_d && keyValid_q && !KeyAck)    overrun_q <= 1'b1;
        else if (!accept_d && KeyAck && keyValid_q)    overrun_q <= 1'b0;
    end

    assign Overrun = overrun_q;
`endif

    assign ROW      = row_q;
    assign KeyCode  = keyCode_q;
    assign KeyData  = keyData_q;
    assign KeyValid = keyValid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2.
module tb_keypad_scanner;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [31:0] KeyData;
   logic [3:0]  KeyCode;
   logic        KeyValid;
   logic        KeyAck;
`ifdef KEYPAD_OVERRUN_EN
   logic        Overrun;
`endif

   logic        pressed;
   logic [1:0]  keyRow;
   logic [1:0]  keyCol;

   int checks = 0;
   int errors = 0;

   logic [3:0] rowExp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] seqCodes [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ROW      (ROW),
      .COL      (COL),
      .KeyData  (KeyData),
      .KeyCode  (KeyCode),
      .KeyValid (KeyValid),
      .KeyAck   (KeyAck)
`ifdef KEYPAD_OVERRUN_EN
      ,
      .Overrun  (Overrun)
`endif
   );

   always #5 CLK = ~CLK;

   // Ideal keypad: the pressed key pulls its column low while its row is driven low.
   always_comb begin
      COL = 4'b1111;
      if (pressed && ROW[keyRow] == 1'b0) COL[keyCol] = 1'b0;
   end

   task automatic waitForValid(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge CLK);
         if (KeyValid === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; KeyAck = 1'b0; pressed = 1'b0; keyRow = 2'd0; keyCol = 2'd0;
      repeat (3) @(negedge CLK);
      checks++; if (ROW !== 4'b1110) begin errors++; $display("[TB] FAIL reset_row: got %b expected %b", ROW, 4'b1110); end
      checks++; if (KeyData !== 32'h0) begin errors++; $display("[TB] FAIL reset_keydata: got %h expected %h", KeyData, 32'h0); end
      checks++; if (KeyCode !== 4'h0) begin errors++; $display("[TB] FAIL reset_keycode: got %h expected %h", KeyCode, 4'h0); end
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_keyvalid: got %b expected 0", KeyValid); end
`ifdef KEYPAD_OVERRUN_EN
      checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", Overrun); end
`endif
      RST = 1'b0;
   endtask

   task automatic test_row_scan();
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         checks++;
         if (ROW !== rowExp[(k / 4) % 4]) begin
            errors++; $display("[TB] FAIL row_scan_cycle%0d: got %b expected %b", k, ROW, rowExp[(k / 4) % 4]);
         end
      end
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL scan_keyvalid: got %b expected 0", KeyValid); end
      checks++; if (KeyData !== 32'h0) begin errors++; $display("[TB] FAIL scan_keydata: got %h expected 0", KeyData); end
   endtask

   task automatic test_ack_idle();
      KeyAck = 1'b1;
      @(negedge CLK);
      KeyAck = 1'b0;
      @(negedge CLK);
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL ack_idle_keyvalid: got %b expected 0", KeyValid); end
   endtask

   task automatic test_stable_press();
      bit seen;
      keyRow = 2'd2; keyCol = 2'd1; pressed = 1'b1;
      waitForValid(200, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL press_valid_timeout: got 0 expected 1"); end
      checks++; if (KeyCode !== 4'h9) begin errors++; $display("[TB] FAIL press_keycode: got %h expected %h", KeyCode, 4'h9); end
      checks++; if (KeyData !== 32'h00000009) begin errors++; $display("[TB] FAIL press_keydata: got %h expected %h", KeyData, 32'h00000009); end
      repeat (10) @(negedge CLK);
      checks++; if (KeyValid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid_held: got %b expected 1", KeyValid); end
      KeyAck = 1'b1;
      @(negedge CLK);
      KeyAck = 1'b0;
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL press_ack_clear: got %b expected 0", KeyValid); end
      pressed = 1'b0;
      repeat (40) @(negedge CLK);
   endtask

   task automatic test_bounce();
      int guard;
      keyRow = 2'd1; keyCol = 2'd0; pressed = 1'b0;
      guard = 0;
      while (ROW === 4'b1101 && guard < 40) begin @(negedge CLK); guard++; end
      while (ROW !== 4'b1101 && guard < 80) begin @(negedge CLK); guard++; end
      checks++; if (ROW !== 4'b1101) begin errors++; $display("[TB] FAIL bounce_row1_timeout: got %b expected %b", ROW, 4'b1101); end
      pressed = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         if (k == 4) begin
            checks++; if (ROW !== 4'b1101) begin errors++; $display("[TB] FAIL bounce_row_held: got %b expected %b", ROW, 4'b1101); end
            pressed = 1'b0;
         end
         if (k == 8) begin
            checks++; if (ROW !== 4'b1011) begin errors++; $display("[TB] FAIL bounce_row_advance: got %b expected %b", ROW, 4'b1011); end
            checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL bounce_no_accept: got %b expected 0", KeyValid); end
         end
         if (k == 12) begin
            checks++; if (ROW !== 4'b0111) begin errors++; $display("[TB] FAIL bounce_scan_resume: got %b expected %b", ROW, 4'b0111); end
         end
      end
      checks++; if (KeyData !== 32'h00000009) begin errors++; $display("[TB] FAIL bounce_keydata: got %h expected %h", KeyData, 32'h00000009); end
   endtask

   task automatic test_history();
      bit seen;
      for (int n = 0; n < 9; n++) begin
         keyRow = seqCodes[n][3:2]; keyCol = seqCodes[n][1:0]; pressed = 1'b1;
         waitForValid(200, seen);
         checks++;
         if (!seen || KeyCode !== seqCodes[n]) begin
            errors++; $display("[TB] FAIL history_code%0d: got %h (valid %b) expected %h", n, KeyCode, seen, seqCodes[n]);
         end
         KeyAck = 1'b1;
         @(negedge CLK);
         KeyAck = 1'b0; pressed = 1'b0;
         repeat (40) @(negedge CLK);
         if (n == 7) begin
            checks++; if (KeyData !== 32'h12345678) begin errors++; $display("[TB] FAIL history_eight: got %h expected %h", KeyData, 32'h12345678); end
         end
      end
      checks++; if (KeyData !== 32'h2345678F) begin errors++; $display("[TB] FAIL history_shift_out: got %h expected %h", KeyData, 32'h2345678F); end
   endtask

   task automatic test_overrun();
      bit seen;
      int guard;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      keyRow = 2'd0; keyCol = 2'd0; pressed = 1'b1;
      waitForValid(200, seen);
      checks++; if (!seen || KeyCode !== 4'h0) begin errors++; $display("[TB] FAIL overrun_first: got %h (valid %b) expected 0", KeyCode, seen); end
`ifdef KEYPAD_OVERRUN_EN
      checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %b expected 0", Overrun); end
`endif
      pressed = 1'b0;
      repeat (40) @(negedge CLK);
      keyRow = 2'd3; keyCol = 2'd2; pressed = 1'b1;
      guard = 0;
      while (KeyCode !== 4'hE && guard < 200) begin @(negedge CLK); guard++; end
      checks++; if (KeyCode !== 4'hE) begin errors++; $display("[TB] FAIL overrun_keycode: got %h expected %h", KeyCode, 4'hE); end
      checks++; if (KeyData !== 32'h0000000E) begin errors++; $display("[TB] FAIL overrun_keydata: got %h expected %h", KeyData, 32'h0000000E); end
      checks++; if (KeyValid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_keyvalid: got %b expected 1", KeyValid); end
`ifdef KEYPAD_OVERRUN_EN
      checks++; if (Overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", Overrun); end
`endif
      KeyAck = 1'b1;
      @(negedge CLK);
      KeyAck = 1'b0;
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ack_valid: got %b expected 0", KeyValid); end
`ifdef KEYPAD_OVERRUN_EN
      checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ack_clear: got %b expected 0", Overrun); end
`endif
      pressed = 1'b0;
      repeat (40) @(negedge CLK);
   endtask

   task automatic test_ack_same_cycle();
      bit seen;
      KeyAck = 1'b1;
      keyRow = 2'd0; keyCol = 2'd3; pressed = 1'b1;
      waitForValid(200, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL accept_beats_ack: got 0 expected 1"); end
      checks++; if (KeyCode !== 4'h3) begin errors++; $display("[TB] FAIL accept_ack_keycode: got %h expected %h", KeyCode, 4'h3); end
      @(negedge CLK);
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL accept_ack_clear: got %b expected 0", KeyValid); end
      KeyAck = 1'b0; pressed = 1'b0;
      repeat (40) @(negedge CLK);
      checks++; if (KeyData !== 32'h000000E3) begin errors++; $display("[TB] FAIL accept_ack_keydata: got %h expected %h", KeyData, 32'h000000E3); end
   endtask

   task automatic test_reset_in_hold();
      bit seen;
      keyRow = 2'd1; keyCol = 2'd2; pressed = 1'b1;
      waitForValid(200, seen);
      checks++; if (!seen || KeyCode !== 4'h6) begin errors++; $display("[TB] FAIL hold_first_accept: got %h (valid %b) expected 6", KeyCode, seen); end
      repeat (10) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++; if (ROW !== 4'b1110) begin errors++; $display("[TB] FAIL hold_reset_row: got %b expected %b", ROW, 4'b1110); end
      checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL hold_reset_valid: got %b expected 0", KeyValid); end
      checks++; if (KeyData !== 32'h0) begin errors++; $display("[TB] FAIL hold_reset_keydata: got %h expected 0", KeyData); end
      checks++; if (KeyCode !== 4'h0) begin errors++; $display("[TB] FAIL hold_reset_keycode: got %h expected 0", KeyCode); end
      RST = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge CLK);
         if (k == 15) begin
            checks++; if (KeyValid !== 1'b0) begin errors++; $display("[TB] FAIL hold_reaccept_early: got %b expected 0", KeyValid); end
         end
      end
      checks++; if (KeyValid !== 1'b1) begin errors++; $display("[TB] FAIL hold_reaccept_valid: got %b expected 1", KeyValid); end
      checks++; if (KeyCode !== 4'h6) begin errors++; $display("[TB] FAIL hold_reaccept_keycode: got %h expected %h", KeyCode, 4'h6); end
      checks++; if (KeyData !== 32'h00000006) begin errors++; $display("[TB] FAIL hold_reaccept_keydata: got %h expected %h", KeyData, 32'h00000006); end
      pressed = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_row_scan();
      test_ack_idle();
      test_stable_press();
      test_bounce();
      test_history();
      test_overrun();
      test_ack_same_cycle();
      test_reset_in_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
